// File: rtl/oam_dma_if.sv
// Bus bundle between the OAM DMA engine and the MMU side of the Game Boy memory system.
// The master modport is the DMA engine; the slave modport is the MMU/memory side.
interface oam_dma_if;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        active;
  logic        done;

  modport master (
    input  reg_wr, reg_wdata, rd_data,
    output reg_rdata, rd_req, rd_addr, wr_req, wr_addr, wr_data, active, done
  );

  modport slave (
    output reg_wr, reg_wdata, rd_data,
    input  reg_rdata, rd_req, rd_addr, wr_req, wr_addr, wr_data, active, done
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: on a write to 0xFF46 copies LENGTH bytes from {src, 8'h00}
// into OAM at 0xFE00, one byte per M-cycle of CYCLES_PER_BYTE clocks.
// Request outputs are computed from the next-state values and registered, so
// they line up with the state/phase they belong to without combinational decode.
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int LENGTH          = 160
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam int              PW         = $clog2(CYCLES_PER_BYTE);
  localparam logic [PW-1:0]   PHASE_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0]   PHASE_WR   = PW'(1);
  localparam logic [7:0]      IDX_LAST   = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     src_q, src_d;
  logic [7:0]     idx_q, idx_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     eff_src_d;
  logic           rd_req_q, rd_req_d;
  logic           wr_req_q, wr_req_d;
  logic           active_q, active_d;
  logic           done_q, done_d;
  logic [15:0]    rd_addr_q, rd_addr_d;
  logic [15:0]    wr_addr_q, wr_addr_d;

  // Next-state and next-output computation; a register write restarts from any state.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rdata_d = rdata_q;
    data_d  = data_q;

    case (state_q)
      START: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          state_d = XFER;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      XFER: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
      end
    endcase

    if (wr_req_q) begin
      data_d = bus.rd_data;
    end

    if (bus.reg_wr) begin
      src_d   = bus.reg_wdata;
      rdata_d = bus.reg_wdata;
      idx_d   = 8'd0;
      phase_d = '0;
      state_d = START;
    end

    eff_src_d = (src_d >= 8'hE0) ? (src_d - 8'h20) : src_d;
    active_d  = (state_d != IDLE);
    rd_req_d  = (state_d == XFER) && (phase_d == '0);
    wr_req_d  = (state_d == XFER) && (phase_d == PHASE_WR);
    rd_addr_d = rd_req_d ? {eff_src_d, idx_d} : rd_addr_q;
    wr_addr_d = wr_req_d ? {8'hFE, idx_d} : wr_addr_q;
    done_d    = (state_d == XFER) && (phase_d == PHASE_LAST) && (idx_d == IDX_LAST);
  end

  // State machine and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      idx_q     <= 8'h00;
      phase_q   <= '0;
      rdata_q   <= 8'hFF;
      data_q    <= 8'h00;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= 16'h0000;
      wr_addr_q <= 16'h0000;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      rdata_q   <= rdata_d;
      data_q    <= data_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  // Read data arrives the cycle after rd_req, which is the write cycle, so it is
  // passed straight through then and held from the latched copy afterwards.
  // A restart landing on the final phase cancels that cycle's done pulse.
  assign bus.reg_rdata = rdata_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_req_q ? bus.rd_data : data_q;
  assign bus.active    = active_q;
  assign bus.done      = done_q & ~bus.reg_wr;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a transfer-level model predicts every output
// each cycle from the time of the last register write, and directed scenarios
// pin the model with hand-computed counts, latencies and addresses.
module tb_oam_dma;

  localparam int CPB         = 4;
  localparam int LEN         = 160;
  localparam int XFER_CYCLES = (LEN + 1) * CPB;

  logic clk = 1'b0;
  logic reset;

  oam_dma_if dma_if ();

  oam_dma #(
    .CYCLES_PER_BYTE(CPB),
    .LENGTH(LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(dma_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  bit         m_started = 1'b0;
  int         m_t0 = 0;
  logic [7:0] m_src = 8'h00;
  logic [7:0] m_rdata = 8'hFF;

  int          n_rd, n_wr, n_done, n_active;
  int          first_rd_cyc, first_wr_cyc, done_cyc;
  logic [15:0] first_rd_addr, last_rd_addr, first_wr_addr, last_wr_addr;

  // Transfer-level model: remembers when the last write was taken and what it wrote.
  always @(posedge clk) begin
    if (!reset) begin
      m_started = 1'b0;
      m_rdata   = 8'hFF;
    end else if (dma_if.reg_wr) begin
      m_started = 1'b1;
      m_t0      = cyc;
      m_src     = dma_if.reg_wdata;
      m_rdata   = dma_if.reg_wdata;
    end
    cyc++;
  end

  // Source memory: returns addr[7:0]^5A one cycle after each read request.
  always @(posedge clk) begin
    if (!reset) begin
      dma_if.rd_data <= 8'h00;
    end else if (dma_if.rd_req) begin
      dma_if.rd_data <= dma_if.rd_addr[7:0] ^ 8'h5A;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] echoMap(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic clearStats();
    n_rd          = 0;
    n_wr          = 0;
    n_done        = 0;
    n_active      = 0;
    first_rd_cyc  = -1;
    first_wr_cyc  = -1;
    done_cyc      = -1;
    first_rd_addr = 16'hxxxx;
    last_rd_addr  = 16'hxxxx;
    first_wr_addr = 16'hxxxx;
    last_wr_addr  = 16'hxxxx;
  endtask

  task automatic applyStimulus(input logic [7:0] val, output int t);
    dma_if.reg_wr    = 1'b1;
    dma_if.reg_wdata = val;
    t = cyc;
    @(posedge clk);
    #1;
    dma_if.reg_wr = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t1, t2;

  // Main sequence plus a per-cycle compare thread against the model.
  initial begin
    reset            = 1'b0;
    dma_if.reg_wr    = 1'b0;
    dma_if.reg_wdata = 8'h00;
    clearStats();

    fork
      forever begin
        int k, m, b, ph;
        logic        e_active, e_rd, e_wr, e_done;
        logic [15:0] e_rd_addr, e_wr_addr;
        logic [7:0]  e_wr_data;
        @(negedge clk);
        if (chk_en) begin
          k = cyc - m_t0;
          e_active  = m_started && (k >= 1) && (k <= XFER_CYCLES);
          e_rd = 1'b0; e_wr = 1'b0; e_done = 1'b0;
          e_rd_addr = 16'h0; e_wr_addr = 16'h0; e_wr_data = 8'h0;
          if (e_active && (k >= 1 + CPB)) begin
            m  = k - 1 - CPB;
            b  = m / CPB;
            ph = m % CPB;
            e_rd      = (ph == 0);
            e_wr      = (ph == 1);
            e_done    = (b == LEN - 1) && (ph == CPB - 1) && !dma_if.reg_wr;
            e_rd_addr = {echoMap(m_src), 8'(b)};
            e_wr_addr = 16'hFE00 + 16'(b);
            e_wr_data = 8'(b) ^ 8'h5A;
          end
          checkOutput("active", dma_if.active, e_active);
          checkOutput("rd_req", dma_if.rd_req, e_rd);
          checkOutput("wr_req", dma_if.wr_req, e_wr);
          checkOutput("done", dma_if.done, e_done);
          checkOutput("reg_rdata", dma_if.reg_rdata, m_rdata);
          if (e_rd) checkOutput("rd_addr", dma_if.rd_addr, e_rd_addr);
          if (e_wr) begin
            checkOutput("wr_addr", dma_if.wr_addr, e_wr_addr);
            checkOutput("wr_data", dma_if.wr_data, e_wr_data);
          end
        end
        if (dma_if.rd_req) begin
          n_rd++;
          if (first_rd_cyc < 0) begin
            first_rd_cyc  = cyc;
            first_rd_addr = dma_if.rd_addr;
          end
          last_rd_addr = dma_if.rd_addr;
        end
        if (dma_if.wr_req) begin
          n_wr++;
          if (first_wr_cyc < 0) begin
            first_wr_cyc  = cyc;
            first_wr_addr = dma_if.wr_addr;
          end
          last_wr_addr = dma_if.wr_addr;
        end
        if (dma_if.done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (dma_if.active) n_active++;
      end
    join_none

    // Reset held for three cycles, then register values checked directly.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset reg_rdata", dma_if.reg_rdata, 16'h00FF);
    checkOutput("reset active", dma_if.active, 1'b0);
    checkOutput("reset rd_req", dma_if.rd_req, 1'b0);
    checkOutput("reset wr_req", dma_if.wr_req, 1'b0);
    checkOutput("reset done", dma_if.done, 1'b0);
    checkOutput("reset rd_addr", dma_if.rd_addr, 16'h0000);
    checkOutput("reset wr_addr", dma_if.wr_addr, 16'h0000);
    checkOutput("reset wr_data", dma_if.wr_data, 16'h0000);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: nothing happens for 20 cycles.
    clearStats();
    waitUntil(cyc + 20);
    checkOutput("idle rd count", 16'(n_rd), 16'd0);
    checkOutput("idle wr count", 16'(n_wr), 16'd0);
    checkOutput("idle active count", 16'(n_active), 16'd0);

    // Basic transfer from C100.
    clearStats();
    applyStimulus(8'hC1, t1);
    waitUntil(t1 + XFER_CYCLES + 10);
    checkOutput("basic first rd latency", 16'(first_rd_cyc - t1), 16'd5);
    checkOutput("basic first wr latency", 16'(first_wr_cyc - t1), 16'd6);
    checkOutput("basic active cycles", 16'(n_active), 16'd644);
    checkOutput("basic rd count", 16'(n_rd), 16'd160);
    checkOutput("basic wr count", 16'(n_wr), 16'd160);
    checkOutput("basic done count", 16'(n_done), 16'd1);
    checkOutput("basic done cycle", 16'(done_cyc - t1), 16'd644);
    checkOutput("basic first rd_addr", first_rd_addr, 16'hC100);
    checkOutput("basic last rd_addr", last_rd_addr, 16'hC19F);
    checkOutput("basic first wr_addr", first_wr_addr, 16'hFE00);
    checkOutput("basic last wr_addr", last_wr_addr, 16'hFE9F);

    // Echo-RAM source: E3 maps down by 0x20 to C3.
    clearStats();
    applyStimulus(8'hE3, t1);
    waitUntil(t1 + XFER_CYCLES + 10);
    checkOutput("echo reg_rdata", dma_if.reg_rdata, 16'h00E3);
    checkOutput("echo first rd_addr", first_rd_addr, 16'hC300);
    checkOutput("echo last rd_addr", last_rd_addr, 16'hC39F);
    checkOutput("echo rd count", 16'(n_rd), 16'd160);

    // Restart at byte 50 phase 2.
    clearStats();
    applyStimulus(8'hC0, t1);
    waitUntil(t1 + 1 + CPB + 50 * CPB + 2);
    clearStats();
    applyStimulus(8'hC8, t2);
    waitUntil(t2 + XFER_CYCLES + 10);
    checkOutput("restart done count", 16'(n_done), 16'd1);
    checkOutput("restart done cycle", 16'(done_cyc - t2), 16'd644);
    checkOutput("restart wr count", 16'(n_wr), 16'd160);
    checkOutput("restart first wr_addr", first_wr_addr, 16'hFE00);
    checkOutput("restart first rd_addr", first_rd_addr, 16'hC800);
    checkOutput("restart last rd_addr", last_rd_addr, 16'hC89F);

    // Restart exactly on the final phase: no done, no gap in active.
    clearStats();
    applyStimulus(8'hC1, t1);
    waitUntil(t1 + XFER_CYCLES);
    clearStats();
    applyStimulus(8'hC4, t2);
    waitUntil(t2 + XFER_CYCLES + 1);
    checkOutput("final restart active cycles", 16'(n_active), 16'd645);
    checkOutput("final restart done count", 16'(n_done), 16'd1);
    checkOutput("final restart done cycle", 16'(done_cyc - t2), 16'd644);
    checkOutput("final restart first rd latency", 16'(first_rd_cyc - t2), 16'd5);
    checkOutput("final restart first rd_addr", first_rd_addr, 16'hC400);

    // Reset at byte 80 aborts, then a clean transfer from C200.
    clearStats();
    applyStimulus(8'hC0, t1);
    waitUntil(t1 + 1 + CPB + 80 * CPB);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearStats();
    @(negedge clk);
    checkOutput("abort active", dma_if.active, 1'b0);
    checkOutput("abort rd_req", dma_if.rd_req, 1'b0);
    checkOutput("abort wr_req", dma_if.wr_req, 1'b0);
    waitUntil(cyc + 10);
    checkOutput("abort rd count", 16'(n_rd), 16'd0);
    checkOutput("abort done count", 16'(n_done), 16'd0);
    clearStats();
    applyStimulus(8'hC2, t2);
    waitUntil(t2 + XFER_CYCLES + 10);
    checkOutput("post-abort rd count", 16'(n_rd), 16'd160);
    checkOutput("post-abort wr count", 16'(n_wr), 16'd160);
    checkOutput("post-abort first rd_addr", first_rd_addr, 16'hC200);
    checkOutput("post-abort last wr_addr", last_wr_addr, 16'hFE9F);
    checkOutput("post-abort done count", 16'(n_done), 16'd1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
